// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: iterative radix-2 restoring divide sequencer for the EX stage.
//
// A divide runs in three steps:
//   1. Capture the operands (absolute values in signed mode).
//   2. Resolve one quotient bit per cycle, MSB first, for DATA_W cycles.
//   3. Apply one cycle of sign correction, then present the result in DONE.
// While a divide is in flight, busy requests a pipeline stall.
//
// Ports:
//   clk        in   rising-edge system clock
//   reset      in   asynchronous active-low reset
//   stall      in   pipeline stall; holds the result in DONE
//   flush      in   pipeline flush; aborts any operation (highest priority)
//   start      in   one-cycle divide request from ID/EX
//   sign       in   1 = signed two's complement divide, 0 = unsigned
//   dividend   in   operand 0
//   divisor    in   operand 1
//   busy       out  stall request to pipeline control
//   done       out  quotient/remainder valid
//   quotient   out  quotient result
//   remainder  out  remainder result (takes the sign of the dividend)
//   div_zero   out  divisor was zero for the current result
//   dbg_state  out  current FSM state (0 IDLE, 1 CALC, 2 FIX, 3 DONE)
//
// Handshake: start is a qualifier sampled only in IDLE. busy rises in the
// same cycle as an accepted start and stays high until the cycle before
// done. done stays high for as long as stall is high and drops in the cycle
// after stall is first seen low. quotient, remainder and div_zero are valid
// only while done is high.
module ex_div_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              start,
  input  logic              sign,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_zero,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // dvd_q shifts the dividend out of its MSB while quotient bits enter at its LSB.
  logic [DATA_W-1:0] dvd_q, dvd_d;
  logic [DATA_W-1:0] dsr_q, dsr_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] remo_q, remo_d;
  logic              dz_q, dz_d;

  logic [DATA_W-1:0] dvd_abs, dsr_abs;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;

  // In signed mode, the most negative value maps to itself. Read as unsigned,
  // that is its correct magnitude.
  assign dvd_abs = (sign && dividend[DATA_W-1]) ? ('0 - dividend) : dividend;
  assign dsr_abs = (sign && divisor[DATA_W-1])  ? ('0 - divisor)  : divisor;

  // The partial remainder is always below the divisor. The shifted value is
  // therefore below twice the divisor. The trial difference lies strictly
  // within +/-2^DATA_W, so DATA_W+1 bits hold it and its MSB is the sign.
  assign shifted = {rem_q, dvd_q[DATA_W-1]};
  assign trial   = shifted - {1'b0, dsr_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_d     = quo_q;
    remo_d    = remo_q;
    dz_d      = dz_q;

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      dz_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            dvd_d     = dvd_abs;
            dsr_d     = dsr_abs;
            rem_d     = '0;
            cnt_d     = '0;
            neg_quo_d = sign & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
            neg_rem_d = sign & dividend[DATA_W-1];
            if (divisor == '0) begin
              quo_d   = '1;
              remo_d  = dividend;
              dz_d    = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          dvd_d = {dvd_q[DATA_W-2:0], ~trial[DATA_W]};
          rem_d = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_FIX;
        end
        S_FIX: begin
          quo_d   = neg_quo_q ? ('0 - dvd_q) : dvd_q;
          remo_d  = neg_rem_q ? ('0 - rem_q) : rem_q;
          dz_d    = 1'b0;
          state_d = S_DONE;
        end
        S_DONE: begin
          if (!stall) begin
            state_d = S_IDLE;
            dz_d    = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      remo_q    <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_q     <= quo_d;
      remo_q    <= remo_d;
      dz_q      <= dz_d;
    end
  end

  // busy follows start combinationally, so the issuing instruction stalls in
  // its first cycle. A flush in CALC/FIX takes effect one edge later.
  assign busy      = ((state_q == S_IDLE) && start && !flush) ||
                     (state_q == S_CALC) || (state_q == S_FIX);
  assign done      = (state_q == S_DONE);
  assign quotient  = quo_q;
  assign remainder = remo_q;
  assign div_zero  = dz_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ex_div_ctrl.sv
module tb_ex_div_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        start;
  logic        sign;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;
  logic [1:0]  dbg_state;

  int n_tests;
  int n_fail;

  ex_div_ctrl #(.DATA_W(32), .CNT_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .start     (start),
    .sign      (sign),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A cycle begins 1 time unit after a rising edge. Outputs are sampled on
  // the falling edge in the middle of the cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // Presents a one-cycle start in the current cycle (cycle 0). Returns the
  // cycle in which done is first seen, or -1 if done does not appear within
  // the budget. On return, the bench sits at the falling edge of that cycle.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic s, output int lat);
    lat      = -1;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sign     = s;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
      next_cycle();
      start = 1'b0;
    end
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    start = 1'b0;
    sign  = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, done, div_zero} !== 3'b000 || quotient !== 32'h0 ||
        remainder !== 32'h0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b dz=%b q=%h r=%h st=%0d, need all zero",
               busy, done, div_zero, quotient, remainder, dbg_state);
    end
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_unsigned();
    bit bad_window;
    bad_window = 1'b0;
    start = 1'b1; dividend = 32'd100; divisor = 32'd7; sign = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_first_cycle: busy=%b need 1", busy);
    end
    for (int c = 1; c <= 33; c++) begin
      next_cycle();
      start = 1'b0;
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0) bad_window = 1'b1;
    end
    n_tests++;
    if (bad_window) begin
      n_fail++;
      $display("FAIL busy_window: busy/done wrong in cycles 1-33, need busy=1 done=0");
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || quotient !== 32'd14 ||
        remainder !== 32'd2 || div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL unsigned_100_7: done=%b busy=%b q=%0d r=%0d dz=%b, need 1 0 14 2 0",
               done, busy, quotient, remainder, div_zero);
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_drop: done=%b at cycle 35, need 0", done);
    end
    next_cycle();
  endtask

  task automatic test_unsigned_edges();
    int lat;
    run_div(32'hFFFF_FFFF, 32'h10, 1'b0, lat);
    n_tests++;
    if (lat !== 34 || quotient !== 32'h0FFF_FFFF || remainder !== 32'hF) begin
      n_fail++;
      $display("FAIL unsigned_max_16: lat=%0d q=%h r=%h, need 34 0fffffff 0000000f",
               lat, quotient, remainder);
    end
    next_cycle();
    run_div(32'd5, 32'd9, 1'b0, lat);
    n_tests++;
    if (lat !== 34 || quotient !== 32'd0 || remainder !== 32'd5) begin
      n_fail++;
      $display("FAIL unsigned_small: lat=%0d q=%0d r=%0d, need 34 0 5", lat, quotient, remainder);
    end
    next_cycle();
  endtask

  task automatic test_signed();
    int lat;
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, lat);
    n_tests++;
    if (lat !== 34 || quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF ||
        div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL signed_m7_2: lat=%0d q=%h r=%h dz=%b, need 34 fffffffd ffffffff 0",
               lat, quotient, remainder, div_zero);
    end
    next_cycle();
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, lat);
    n_tests++;
    if (lat !== 34 || quotient !== 32'hFFFF_FFFD || remainder !== 32'd1) begin
      n_fail++;
      $display("FAIL signed_7_m2: lat=%0d q=%h r=%h, need 34 fffffffd 00000001",
               lat, quotient, remainder);
    end
    next_cycle();
  endtask

  task automatic test_div_zero();
    int lat;
    for (int s = 0; s < 2; s++) begin
      run_div(32'h1234_5678, 32'h0, s[0], lat);
      n_tests++;
      if (lat !== 1 || quotient !== 32'hFFFF_FFFF || remainder !== 32'h1234_5678 ||
          div_zero !== 1'b1) begin
        n_fail++;
        $display("FAIL div_zero_s%0d: lat=%0d q=%h r=%h dz=%b, need 1 ffffffff 12345678 1",
                 s, lat, quotient, remainder, div_zero);
      end
      next_cycle();
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || div_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL div_zero_clear_s%0d: done=%b dz=%b, need 0 0", s, done, div_zero);
      end
      next_cycle();
    end
  endtask

  task automatic test_flush();
    int lat;
    bit saw_done;
    saw_done = 1'b0;
    start = 1'b1; dividend = 32'd100; divisor = 32'd7; sign = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      start = 1'b0;
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    next_cycle();
    flush = 1'b1;
    start = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_busy_same_cycle: busy=%b need 1 in CALC", busy);
    end
    next_cycle();
    flush = 1'b0;
    start = 1'b0;
    @(negedge clk);
    if (done) saw_done = 1'b1;
    n_tests++;
    if (busy !== 1'b0 || saw_done || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL flush_abort: busy=%b saw_done=%b st=%0d, need 0 0 0",
               busy, saw_done, dbg_state);
    end
    next_cycle();
    run_div(32'd9, 32'd3, 1'b0, lat);
    n_tests++;
    if (lat !== 34 || quotient !== 32'd3 || remainder !== 32'd0) begin
      n_fail++;
      $display("FAIL flush_restart_9_3: lat=%0d q=%0d r=%0d, need 34 3 0",
               lat, quotient, remainder);
    end
    next_cycle();
  endtask

  task automatic test_flush_idle();
    flush = 1'b1;
    start = 1'b1; dividend = 32'd10; divisor = 32'd2; sign = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_busy: busy=%b need 0", busy);
    end
    next_cycle();
    flush = 1'b0;
    start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL flush_start_ignored: busy=%b done=%b st=%0d, need 0 0 0",
               busy, done, dbg_state);
    end
    next_cycle();
  endtask

  task automatic test_done_hold();
    int lat;
    bit bad_hold;
    bad_hold = 1'b0;
    run_div(32'd100, 32'd7, 1'b0, lat);
    // Cycle 34: keep the result and offer a new start that must be ignored.
    stall = 1'b1;
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    n_tests++;
    if (lat !== 34) begin
      n_fail++;
      $display("FAIL hold_latency: lat=%0d need 34", lat);
    end
    for (int c = 35; c <= 37; c++) begin
      next_cycle();
      if (c == 37) stall = 1'b0;
      @(negedge clk);
      if (done !== 1'b1 || busy !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2)
        bad_hold = 1'b1;
    end
    n_tests++;
    if (bad_hold) begin
      n_fail++;
      $display("FAIL done_hold: done/busy/result unstable in cycles 35-37, need 1 0 14 2");
    end
    next_cycle();
    start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: done=%b busy=%b at cycle 38, need 0 0", done, busy);
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL hold_no_new_op: busy=%b st=%0d, need 0 0", busy, dbg_state);
    end
    next_cycle();
  endtask

  task automatic test_overflow_and_reset();
    int lat;
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat);
    n_tests++;
    if (lat !== 34 || quotient !== 32'h8000_0000 || remainder !== 32'h0) begin
      n_fail++;
      $display("FAIL signed_overflow: lat=%0d q=%h r=%h, need 34 80000000 00000000",
               lat, quotient, remainder);
    end
    next_cycle();
    start = 1'b1; dividend = 32'd100; divisor = 32'd7; sign = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      next_cycle();
      start = 1'b0;
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'h0 || remainder !== 32'h0 ||
        div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_op: busy=%b done=%b q=%h r=%h dz=%b, need all zero",
               busy, done, quotient, remainder, div_zero);
    end
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_unsigned();
    test_unsigned_edges();
    test_signed();
    test_div_zero();
    test_flush();
    test_flush_idle();
    test_done_hold();
    test_overflow_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
